// File: rtl/sdram_fb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared types and default constants for the SDRAM frame-buffer arbiter:
//   state_t  - arbiter FSM states
//   gnt_t    - which requester was granted most recently
//   DEF_*    - default parameter values
//   cnt_w()  - width of the burst issued/returned counters
// -----------------------------------------------------------------------------
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

    localparam int DEF_ADDR_W    = 25;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_MAX_OUT   = 8;

    // One extra bit so the counters can hold the value BURST_LEN itself.
    function automatic int cnt_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/sdram_fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus bundles for sdram_fb_arbiter.
//   fb_req_if : requester side (VGA burst reader + pixel writer).
//               master = requesters, slave = arbiter.
//   fb_avm_if : Avalon-MM link to the SDRAM controller.
//               master = arbiter, slave = SDRAM controller.
// -----------------------------------------------------------------------------
interface fb_req_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_grant, rd_data, rd_valid, rd_done, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_grant, rd_data, rd_valid, rd_done, wr_ack
    );
endinterface

interface fb_avm_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sdram_fb_arbiter_rd_tracker.sv
// -----------------------------------------------------------------------------
// sdram_rd_tracker
// Issued/returned word counters for one read burst.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clear_i          : hold both counters at zero (no burst in flight)
//   issue_i          : a read command was accepted by the SDRAM this cycle
//   ret_i            : a read word came back this cycle
//   issued_d_o       : issued count as it will be after this edge
//   read_ok_o        : another read may be presented next cycle
//   all_issued_o     : the whole burst will have been issued after this edge
//   all_returned_o   : the whole burst will have returned after this edge
// The outputs look one edge ahead so the arbiter can register avm_read and
// avm_address directly from them.
// -----------------------------------------------------------------------------
module sdram_rd_tracker
    import fb_arb_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MAX_OUT   = DEF_MAX_OUT,
    parameter int CW        = cnt_w(DEF_BURST_LEN)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          issue_i,
    input  logic          ret_i,
    output logic [CW-1:0] issued_d_o,
    output logic          read_ok_o,
    output logic          all_issued_o,
    output logic          all_returned_o
);
    localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);
    localparam logic [CW-1:0] MO_C = CW'(MAX_OUT);

    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] returned_q, returned_d;
    logic [CW-1:0] outstanding;

    always_comb begin
        issued_d   = issued_q;
        returned_d = returned_q;
        if (clear_i) begin
            issued_d   = '0;
            returned_d = '0;
        end else begin
            if (issue_i) issued_d   = issued_q + CW'(1);
            if (ret_i)   returned_d = returned_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q   <= '0;
            returned_q <= '0;
        end else begin
            issued_q   <= issued_d;
            returned_q <= returned_d;
        end
    end

    // Outstanding can never exceed MAX_OUT, so equality is the stall test.
    assign outstanding    = issued_d - returned_d;
    assign issued_d_o     = issued_d;
    assign all_issued_o   = (issued_d == BL_C);
    assign all_returned_o = (returned_d == BL_C);
    assign read_ok_o      = (issued_d != BL_C) && (outstanding != MO_C);

endmodule

// File: rtl/sdram_fb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_fb_arbiter
// Shares one SDRAM Avalon-MM slave between the VGA line-prefetch reader
// (fixed-length pipelined read bursts) and the pixel writer (single writes).
// Ties alternate round-robin; read pipelining is capped at MAX_OUT words.
//   CLOCK_50 : system clock (rising edge)
//   reset    : synchronous active-high reset
//   req      : fb_req_if.slave  - rd_req/rd_addr/rd_grant/rd_data/rd_valid/
//              rd_done, wr_req/wr_addr/wr_data/wr_ack
//   avm      : fb_avm_if.master - Avalon-MM command/response to SDRAM
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdram_fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MAX_OUT   = DEF_MAX_OUT
) (
    input  logic     CLOCK_50,
    input  logic     reset,
    fb_req_if.slave  req,
    fb_avm_if.master avm
);
    localparam int CW = cnt_w(BURST_LEN);

    state_t            state_q, state_d;
    gnt_t              last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              grant_q, grant_d, ack_q, ack_d;
    logic              rvalid_q, rvalid_d, rdone_q, rdone_d;

    logic              in_rd, issue, ret, take_rd;
    logic [CW-1:0]     issued_d;
    logic              read_ok, all_issued, all_returned;

    assign in_rd = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
    assign issue = (state_q == RD_ISSUE) && rd_q && !avm.avm_waitrequest;
    // Read data arriving outside a burst (e.g. after a reset) is dropped.
    assign ret   = in_rd && avm.avm_readdatavalid;
    // On a tie the read wins unless the previous grant was a read.
    assign take_rd = req.rd_req && (!req.wr_req || (last_q == GNT_WR));

    sdram_rd_tracker #(
        .BURST_LEN (BURST_LEN),
        .MAX_OUT   (MAX_OUT),
        .CW        (CW)
    ) u_trk (
        .clk_i          (CLOCK_50),
        .rst_i          (reset),
        .clear_i        (!in_rd),
        .issue_i        (issue),
        .ret_i          (ret),
        .issued_d_o     (issued_d),
        .read_ok_o      (read_ok),
        .all_issued_o   (all_issued),
        .all_returned_o (all_returned)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        grant_d  = 1'b0;
        ack_d    = 1'b0;
        rvalid_d = ret;
        rdone_d  = ret && all_returned;
        rdata_d  = avm.avm_readdata;
        case (state_q)
            IDLE: begin
                if (take_rd) begin
                    state_d = RD_ISSUE;
                    grant_d = 1'b1;
                    rd_d    = 1'b1;
                    base_d  = req.rd_addr;
                    addr_d  = req.rd_addr;
                end else if (req.wr_req) begin
                    state_d = WR;
                    wr_d    = 1'b1;
                    addr_d  = req.wr_addr;
                    wdata_d = req.wr_data;
                end
            end
            RD_ISSUE: begin
                // Address wraps modulo 2^ADDR_W through the truncating add.
                addr_d = base_q + ADDR_W'(issued_d);
                rd_d   = read_ok;
                if (all_issued) state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (all_returned) begin
                    state_d = IDLE;
                    last_d  = GNT_RD;
                end
            end
            WR: begin
                if (!avm.avm_waitrequest) begin
                    state_d = IDLE;
                    last_d  = GNT_WR;
                    ack_d   = 1'b1;
                end else begin
                    wr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= GNT_WR;
            base_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            grant_q  <= 1'b0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdone_q  <= rdone_d;
        end
    end

    assign req.rd_grant      = grant_q;
    assign req.rd_data       = rdata_q;
    assign req.rd_valid      = rvalid_q;
    assign req.rd_done       = rdone_q;
    assign req.wr_ack        = ack_q;
    assign avm.avm_address   = addr_q;
    assign avm.avm_read      = rd_q;
    assign avm.avm_write     = wr_q;
    assign avm.avm_writedata = wdata_q;

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_fb_arbiter: an SDRAM slave model with fixed read
// latency and programmable write stall, plus directed scenario tasks.
// -----------------------------------------------------------------------------
module tb_sdram_fb_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 16;
    localparam int MO = 8;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #5 CLOCK_50 = ~CLOCK_50;

    fb_req_if #(.ADDR_W(AW), .DATA_W(DW)) rq ();
    fb_avm_if #(.ADDR_W(AW), .DATA_W(DW)) av ();

    sdram_fb_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .MAX_OUT   (MO)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .req      (rq),
        .avm      (av)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // SDRAM model / monitor state
    int                cyc = 0;
    int                lat = 2;
    int                stall_cnt = 0;
    int                due_q[$];
    logic [DW-1:0]     dat_q[$];
    logic [AW-1:0]     addr_log[$];
    int                acyc_log[$];
    logic [DW-1:0]     rdat_log[$];
    int                done_cnt, done_pos, out_cnt, max_out;
    int                iss_at_ret, ret_seen, wr_acc_cnt;
    int                both_cnt = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    always @(negedge CLOCK_50) begin
        cyc++;
        if (av.avm_write && stall_cnt > 0) begin
            av.avm_waitrequest = 1'b1;
            stall_cnt--;
        end else begin
            av.avm_waitrequest = 1'b0;
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            av.avm_readdatavalid = 1'b1;
            av.avm_readdata      = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
            out_cnt--;
            if (ret_seen == 0) iss_at_ret = addr_log.size();
            ret_seen++;
        end else begin
            av.avm_readdatavalid = 1'b0;
            av.avm_readdata      = 16'hDEAD;
        end
        if (av.avm_read && !av.avm_waitrequest) begin
            due_q.push_back(cyc + lat);
            dat_q.push_back(mem_word(av.avm_address));
            addr_log.push_back(av.avm_address);
            acyc_log.push_back(cyc);
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
        end
        if (av.avm_write && !av.avm_waitrequest) wr_acc_cnt++;
        if (av.avm_read && av.avm_write) both_cnt++;
        if (rq.rd_valid) rdat_log.push_back(rq.rd_data);
        if (rq.rd_done) begin
            done_cnt++;
            done_pos = rdat_log.size();
        end
    end

    task automatic clear_logs();
        addr_log.delete();
        acyc_log.delete();
        rdat_log.delete();
        done_cnt = 0; done_pos = 0; out_cnt = 0; max_out = 0;
        iss_at_ret = 0; ret_seen = 0; wr_acc_cnt = 0;
    endtask

    // Raise rd_req, wait for rd_grant, drop rd_req in the grant cycle.
    task automatic req_read(input logic [AW-1:0] a, output int wc);
        rq.rd_addr = a;
        rq.rd_req  = 1'b1;
        wc = 0;
        do begin
            @(negedge CLOCK_50);
            wc++;
        end while (!rq.rd_grant && wc < 50);
        rq.rd_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLOCK_50);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rq.rd_req = 1'b0; rq.wr_req = 1'b0;
        rq.rd_addr = '0; rq.wr_addr = '0; rq.wr_data = '0;
        repeat (3) @(negedge CLOCK_50);
        n_checks++;
        if ({rq.rd_grant, rq.rd_valid, rq.rd_done, rq.wr_ack, av.avm_read, av.avm_write} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {rq.rd_grant, rq.rd_valid, rq.rd_done, rq.wr_ack, av.avm_read, av.avm_write});
        end
        n_checks++;
        if (av.avm_address !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", av.avm_address);
        end
        n_checks++;
        if (av.avm_writedata !== '0 || rq.rd_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got wd=%h rd=%h expected 0", av.avm_writedata, rq.rd_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        n_checks++;
        if (av.avm_read !== 1'b0 || av.avm_write !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got rd=%b wr=%b expected 0", av.avm_read, av.avm_write);
        end
    endtask

    task automatic test_single_burst();
        int wc, errs;
        bit ok;
        clear_logs();
        lat = 2;
        req_read(25'h100, wc);
        n_checks++;
        if (wc !== 1 || av.avm_read !== 1'b1 || av.avm_address !== 25'h100) begin
            n_fail++;
            $display("FAIL single_first: got wait=%0d rd=%b addr=%h expected 1 1 100", wc, av.avm_read, av.avm_address);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: got no rd_done expected rd_done"); end
        errs = 0;
        for (int i = 0; i < BL; i++)
            if (i >= addr_log.size() || addr_log[i] !== 25'h100 + AW'(i)) errs++;
        n_checks++;
        if (errs != 0 || addr_log.size() != BL) begin
            n_fail++; $display("FAIL single_addr: got %0d bad of %0d expected 0 bad of 16", errs, addr_log.size());
        end
        n_checks++;
        if (acyc_log.size() != BL || acyc_log[BL-1] - acyc_log[0] != BL - 1) begin
            n_fail++; $display("FAIL single_b2b: got %0d issues not on consecutive cycles expected 16 consecutive", acyc_log.size());
        end
        errs = 0;
        for (int i = 0; i < BL; i++)
            if (i >= rdat_log.size() || rdat_log[i] !== mem_word(25'h100 + AW'(i))) errs++;
        n_checks++;
        if (errs != 0 || rdat_log.size() != BL) begin
            n_fail++; $display("FAIL single_data: got %0d bad of %0d expected 0 bad of 16", errs, rdat_log.size());
        end
        n_checks++;
        if (done_cnt != 1 || done_pos != BL) begin
            n_fail++; $display("FAIL single_done: got cnt=%0d pos=%0d expected 1 16", done_cnt, done_pos);
        end
    endtask

    task automatic test_outstanding();
        int wc, errs;
        bit ok;
        clear_logs();
        lat = 20;
        req_read(25'h200, wc);
        wait_done(600, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL outst_timeout: got no rd_done expected rd_done"); end
        n_checks++;
        if (max_out != MO) begin
            n_fail++; $display("FAIL outst_max: got %0d expected %0d", max_out, MO);
        end
        n_checks++;
        if (iss_at_ret != MO) begin
            n_fail++; $display("FAIL outst_stall: got %0d issues before first return expected %0d", iss_at_ret, MO);
        end
        errs = 0;
        for (int i = 0; i < BL; i++)
            if (i >= rdat_log.size() || rdat_log[i] !== mem_word(25'h200 + AW'(i))) errs++;
        n_checks++;
        if (errs != 0 || rdat_log.size() != BL || done_cnt != 1) begin
            n_fail++; $display("FAIL outst_data: got %0d bad of %0d done=%0d expected 0 of 16 done=1",
                               errs, rdat_log.size(), done_cnt);
        end
    endtask

    task automatic test_round_robin();
        int ord[$];
        int exp_ord[4] = '{1, 2, 1, 2};
        int got;
        clear_logs();
        lat = 2;
        rq.rd_addr = 25'h300; rq.wr_addr = 25'h40; rq.wr_data = 16'h1111;
        rq.rd_req = 1'b1; rq.wr_req = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        for (int k = 0; k < 400 && ord.size() < 4; k++) begin
            @(negedge CLOCK_50);
            if (rq.rd_grant) ord.push_back(1);
            if (rq.wr_ack)   ord.push_back(2);
            if (ord.size() >= 4) begin
                rq.rd_req = 1'b0; rq.wr_req = 1'b0;
            end
        end
        rq.rd_req = 1'b0; rq.wr_req = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        for (int i = 0; i < 4; i++) begin
            got = (i < ord.size()) ? ord[i] : 0;
            n_checks++;
            if (got != exp_ord[i]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d (1=rd 2=wr)", i, got, exp_ord[i]);
            end
        end
        n_checks++;
        if (wr_acc_cnt != 2 || done_cnt != 2) begin
            n_fail++; $display("FAIL rr_counts: got wr=%0d bursts=%0d expected 2 2", wr_acc_cnt, done_cnt);
        end
    endtask

    task automatic test_write_stall();
        int  wcyc = 0, acks = 0;
        bit  stable = 1'b1, overlap = 1'b0;
        logic first_w;
        clear_logs();
        stall_cnt = 5;
        rq.wr_addr = 25'h1234; rq.wr_data = 16'hBEEF;
        rq.wr_req = 1'b1;
        @(negedge CLOCK_50);
        first_w = av.avm_write;
        for (int k = 0; k < 30; k++) begin
            if (av.avm_write) begin
                wcyc++;
                if (av.avm_address !== 25'h1234 || av.avm_writedata !== 16'hBEEF) stable = 1'b0;
            end
            if (rq.wr_ack) begin
                acks++;
                if (av.avm_write) overlap = 1'b1;
                rq.wr_req = 1'b0;
            end
            @(negedge CLOCK_50);
        end
        n_checks++;
        if (first_w !== 1'b1) begin n_fail++; $display("FAIL wr_latency: got avm_write=%b expected 1", first_w); end
        n_checks++;
        if (wcyc != 6) begin n_fail++; $display("FAIL wr_hold: got %0d cycles expected 6", wcyc); end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL wr_stable: got changing addr/data expected stable"); end
        n_checks++;
        if (acks != 1 || overlap || wr_acc_cnt != 1) begin
            n_fail++; $display("FAIL wr_ack: got acks=%0d overlap=%0d accepts=%0d expected 1 0 1", acks, overlap, wr_acc_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        int wc, errs;
        bit ok;
        logic [AW-1:0] base = 25'h1FFFFFC;
        clear_logs();
        lat = 2;
        req_read(base, wc);
        n_checks++;
        if (av.avm_address !== base) begin
            n_fail++; $display("FAIL wrap_first: got %h expected %h", av.avm_address, base);
        end
        wait_done(200, ok);
        errs = 0;
        for (int i = 0; i < BL; i++)
            if (i >= addr_log.size() || addr_log[i] !== base + AW'(i)) errs++;
        n_checks++;
        if (errs != 0 || addr_log.size() != BL) begin
            n_fail++; $display("FAIL wrap_seq: got %0d bad of %0d expected 0 of 16", errs, addr_log.size());
        end
        n_checks++;
        if (addr_log.size() != BL || addr_log[4] !== 25'h0 || addr_log[15] !== 25'hB) begin
            n_fail++; $display("FAIL wrap_ends: got size=%0d expected [4]=0 [15]=B", addr_log.size());
        end
        n_checks++;
        if (!ok || rdat_log.size() != BL || done_cnt != 1) begin
            n_fail++; $display("FAIL wrap_done: got words=%0d done=%0d expected 16 1", rdat_log.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int wc, n_iss, late_v, errs;
        bit ok;
        clear_logs();
        lat = 10;
        req_read(25'h500, wc);
        n_iss = 1;
        for (int k = 0; k < 20 && n_iss < 5; k++) begin
            @(negedge CLOCK_50);
            if (av.avm_read) n_iss++;
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        n_checks++;
        if ({rq.rd_grant, rq.rd_valid, rq.rd_done, rq.wr_ack, av.avm_read, av.avm_write} !== 6'b0
            || av.avm_address !== '0) begin
            n_fail++; $display("FAIL midrst_out: got ctrl=%b addr=%h expected 0 0",
                {rq.rd_grant, rq.rd_valid, rq.rd_done, rq.wr_ack, av.avm_read, av.avm_write}, av.avm_address);
        end
        late_v = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CLOCK_50);
            if (rq.rd_valid || rq.rd_done) late_v++;
        end
        n_checks++;
        if (late_v != 0 || addr_log.size() != 5) begin
            n_fail++; $display("FAIL midrst_drop: got late=%0d issued=%0d expected 0 5", late_v, addr_log.size());
        end
        clear_logs();
        lat = 2;
        req_read(25'h600, wc);
        wait_done(200, ok);
        errs = 0;
        for (int i = 0; i < BL; i++)
            if (i >= rdat_log.size() || rdat_log[i] !== mem_word(25'h600 + AW'(i))) errs++;
        n_checks++;
        if (!ok || errs != 0 || rdat_log.size() != BL || done_cnt != 1 || done_pos != BL) begin
            n_fail++; $display("FAIL midrst_next: got bad=%0d words=%0d done=%0d expected 0 16 1",
                               errs, rdat_log.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_outstanding();
        test_round_robin();
        test_write_stall();
        test_addr_wrap();
        test_reset_mid_burst();
        n_checks++;
        if (both_cnt != 0) begin
            n_fail++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
